reorder_buffer_param: RTL and testbench

Parametrised in-order-commit reorder buffer for the out-of-order RISC-V core, sitting between the dispatcher, the CDB (ALU and LSU result ports), the register file, the LSB and the branch predictor. It generalises the fixed 16-entry ROB with the following changes:
- configurable depth and almost-full margin;
- same-cycle CDB bypass on operand lookup;
- self-flush on a mispredicted branch at commit.

Entry IDs are 1-based; ID 0 means "no entry".

---
 rtl/reorder_buffer_param_if.sv | 77 +++++++
 rtl/reorder_buffer_param.sv | 208 ++++++++++++++++++++
 tb/tb_reorder_buffer_param.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_param_if.sv
// reorder_buffer_param_if: bundle of every ROB-facing signal. It covers the
// dispatcher allocation port, the operand lookup ports and the CDB (ALU/LSU)
// broadcast ports. It also carries the LSB IO mark and head query, the
// registered commit, flush and predictor-update outputs, and the occupancy
// flags.
//   master : the core side (dispatcher, CDB, LSB); drives the ROB inputs
//   slave  : the reorder buffer itself
interface reorder_buffer_param_if #(
    parameter int DEPTH = 16,
    parameter int ID_W  = $clog2(DEPTH) + 1,
    parameter int XLEN  = 32
);
    // allocation
    logic            alloc_valid;
    logic            alloc_is_jump;
    logic            alloc_is_store;
    logic            alloc_pred_taken;
    logic [4:0]      alloc_rd;
    logic [XLEN-1:0] alloc_pc;
    logic [XLEN-1:0] alloc_rollback_pc;
    logic [ID_W-1:0] alloc_id;
    // operand lookup
    logic [ID_W-1:0] q1_id;
    logic [ID_W-1:0] q2_id;
    logic            q1_ready;
    logic            q2_ready;
    logic [XLEN-1:0] v1;
    logic [XLEN-1:0] v2;
    // CDB
    logic            alu_valid;
    logic [ID_W-1:0] alu_id;
    logic [XLEN-1:0] alu_value;
    logic [XLEN-1:0] alu_target_pc;
    logic            alu_taken;
    logic            lsu_valid;
    logic [ID_W-1:0] lsu_id;
    logic [XLEN-1:0] lsu_value;
    // LSB IO handling
    logic [ID_W-1:0] io_mark_id;
    logic [ID_W-1:0] io_head_id;
    // commit / redirect / predictor update
    logic            commit_valid;
    logic [ID_W-1:0] commit_id;
    logic [4:0]      commit_rd;
    logic [XLEN-1:0] commit_value;
    logic            flush;
    logic [XLEN-1:0] flush_pc;
    logic            bp_valid;
    logic [XLEN-1:0] bp_pc;
    logic            bp_taken;
    // occupancy
    logic            full;
    logic            almost_full;
    logic            empty;

    modport master (
        output alloc_valid, alloc_is_jump, alloc_is_store, alloc_pred_taken,
               alloc_rd, alloc_pc, alloc_rollback_pc, q1_id, q2_id,
               alu_valid, alu_id, alu_value, alu_target_pc, alu_taken,
               lsu_valid, lsu_id, lsu_value, io_mark_id,
        input  alloc_id, q1_ready, q2_ready, v1, v2, io_head_id,
               commit_valid, commit_id, commit_rd, commit_value,
               flush, flush_pc, bp_valid, bp_pc, bp_taken,
               full, almost_full, empty
    );

    modport slave (
        input  alloc_valid, alloc_is_jump, alloc_is_store, alloc_pred_taken,
               alloc_rd, alloc_pc, alloc_rollback_pc, q1_id, q2_id,
               alu_valid, alu_id, alu_value, alu_target_pc, alu_taken,
               lsu_valid, lsu_id, lsu_value, io_mark_id,
        output alloc_id, q1_ready, q2_ready, v1, v2, io_head_id,
               commit_valid, commit_id, commit_rd, commit_value,
               flush, flush_pc, bp_valid, bp_pc, bp_taken,
               full, almost_full, empty
    );
endinterface

// File: rtl/reorder_buffer_param.sv
// reorder_buffer_param: parametrised in-order-commit reorder buffer.
// Entry IDs are 1-based (ID = index + 1); ID 0 means "no entry".
// The buffer commits at most one entry per cycle from the head. A committing
// jump whose resolved direction differs from its prediction flushes the whole
// buffer.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   rdy      : global enable; when low every register holds
//   bus      : reorder_buffer_param_if.slave. It carries allocation, operand
//              lookup with same-cycle CDB bypass, and the CDB writes. It also
//              carries the IO mark/head query, the registered commit, flush
//              and predictor-update pulses, and the full/almost_full/empty
//              flags.
// Optional feature (macro ROB_PERF_CNT_EN): adds perf_commit_cnt and
// perf_flush_cnt outputs that count commits and flushes.
module reorder_buffer_param #(
    parameter int DEPTH        = 16,
    parameter int ID_W         = $clog2(DEPTH) + 1,
    parameter int XLEN         = 32,
    parameter int AFULL_MARGIN = 3
) (
    input logic                   clk,
    input logic                   rst,
    input logic                   rdy,
    reorder_buffer_param_if.slave bus
`ifdef ROB_PERF_CNT_EN
    ,
    output logic [XLEN-1:0]       perf_commit_cnt,
    output logic [XLEN-1:0]       perf_flush_cnt
`endif
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [ID_W-1:0] count;

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] ready_q;
    logic [DEPTH-1:0] is_io;
    logic [DEPTH-1:0] is_jump;
    logic [DEPTH-1:0] is_store;
    logic [DEPTH-1:0] pred_taken;
    logic [DEPTH-1:0] taken;
    logic [XLEN-1:0]  pc_q       [DEPTH];
    logic [XLEN-1:0]  target_q   [DEPTH];
    logic [XLEN-1:0]  rollback_q [DEPTH];
    logic [XLEN-1:0]  val_q      [DEPTH];
    logic [4:0]       rd_q       [DEPTH];

    logic            commit_fire;
    logic            mispredict;
    logic            do_alloc;
    logic            full_w;
    logic            alu_hit;
    logic            lsu_hit;
    logic            io_hit;
    logic [PW-1:0]   alu_idx;
    logic [PW-1:0]   lsu_idx;
    logic [PW-1:0]   io_idx;

    function automatic logic [PW-1:0] tag_idx(input logic [ID_W-1:0] tag);
        logic [ID_W-1:0] t;
        t = tag - ID_W'(1);
        return t[PW-1:0];
    endfunction

    function automatic logic [ID_W-1:0] id_of(input logic [PW-1:0] idx);
        return ID_W'(idx) + ID_W'(1);
    endfunction

    // Returns {ready, value}; in-flight broadcasts bypass the stored state,
    // with the LSU port taking priority over the ALU port.
    function automatic logic [XLEN:0] lookup(input logic [ID_W-1:0] tag);
        logic [PW-1:0] i;
        i = tag_idx(tag);
        if (tag == '0)
            return '0;
        if (bus.lsu_valid && bus.lsu_id == tag)
            return {1'b1, bus.lsu_value};
        if (bus.alu_valid && bus.alu_id == tag)
            return {1'b1, bus.alu_value};
        if (busy[i] && ready_q[i])
            return {1'b1, val_q[i]};
        return '0;
    endfunction

    always_comb begin
        full_w      = (count == ID_W'(DEPTH));
        alu_idx     = tag_idx(bus.alu_id);
        lsu_idx     = tag_idx(bus.lsu_id);
        io_idx      = tag_idx(bus.io_mark_id);
        commit_fire = busy[head] && (ready_q[head] || is_store[head]);
        mispredict  = commit_fire && is_jump[head] && (taken[head] != pred_taken[head]);
        do_alloc    = bus.alloc_valid && !full_w;
        alu_hit     = bus.alu_valid && (bus.alu_id != '0) && busy[alu_idx];
        lsu_hit     = bus.lsu_valid && (bus.lsu_id != '0) && busy[lsu_idx];
        io_hit      = (bus.io_mark_id != '0) && busy[io_idx];
    end

    always_comb begin
        bus.alloc_id    = id_of(tail);
        bus.full        = full_w;
        bus.empty       = (count == '0);
        bus.almost_full = (count >= ID_W'(DEPTH - AFULL_MARGIN));
        bus.io_head_id  = (busy[head] && is_io[head]) ? id_of(head) : '0;
        {bus.q1_ready, bus.v1} = lookup(bus.q1_id);
        {bus.q2_ready, bus.v2} = lookup(bus.q2_id);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            busy             <= '0;
            ready_q          <= '0;
            is_io            <= '0;
            bus.commit_valid <= 1'b0;
            bus.commit_id    <= '0;
            bus.commit_rd    <= '0;
            bus.commit_value <= '0;
            bus.flush        <= 1'b0;
            bus.flush_pc     <= '0;
            bus.bp_valid     <= 1'b0;
            bus.bp_pc        <= '0;
            bus.bp_taken     <= 1'b0;
        end else if (rdy) begin
            bus.commit_valid <= commit_fire;
            bus.flush        <= mispredict;
            bus.bp_valid     <= commit_fire && is_jump[head];
            if (commit_fire) begin
                bus.commit_id    <= id_of(head);
                bus.commit_rd    <= rd_q[head];
                bus.commit_value <= val_q[head];
            end
            if (commit_fire && is_jump[head]) begin
                bus.bp_pc    <= pc_q[head];
                bus.bp_taken <= taken[head];
            end
            if (mispredict)
                bus.flush_pc <= taken[head] ? target_q[head] : rollback_q[head];

            if (mispredict) begin
                // Everything younger than the mispredicted jump is wrong-path.
                busy    <= '0;
                ready_q <= '0;
                is_io   <= '0;
                head    <= '0;
                tail    <= '0;
                count   <= '0;
            end else begin
                if (alu_hit) begin
                    ready_q[alu_idx]  <= 1'b1;
                    val_q[alu_idx]    <= bus.alu_value;
                    target_q[alu_idx] <= bus.alu_target_pc;
                    taken[alu_idx]    <= bus.alu_taken;
                end
                // Placed after the ALU write so the LSU value wins on a clash.
                if (lsu_hit) begin
                    ready_q[lsu_idx] <= 1'b1;
                    val_q[lsu_idx]   <= bus.lsu_value;
                end
                if (io_hit)
                    is_io[io_idx] <= 1'b1;
                // Clearing after the CDB/IO writes discards any write that
                // lands on the head while it commits.
                if (commit_fire) begin
                    busy[head]    <= 1'b0;
                    ready_q[head] <= 1'b0;
                    is_io[head]   <= 1'b0;
                    head          <= head + PW'(1);
                end
                if (do_alloc) begin
                    busy[tail]       <= 1'b1;
                    ready_q[tail]    <= 1'b0;
                    is_io[tail]      <= 1'b0;
                    is_jump[tail]    <= bus.alloc_is_jump;
                    is_store[tail]   <= bus.alloc_is_store;
                    pred_taken[tail] <= bus.alloc_pred_taken;
                    taken[tail]      <= 1'b0;
                    val_q[tail]      <= '0;
                    rd_q[tail]       <= bus.alloc_rd;
                    pc_q[tail]       <= bus.alloc_pc;
                    rollback_q[tail] <= bus.alloc_rollback_pc;
                    tail             <= tail + PW'(1);
                end
                count <= count + ID_W'(do_alloc) - ID_W'(commit_fire);
            end
        end
    end

`ifdef ROB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_commit_cnt <= '0;
            perf_flush_cnt  <= '0;
        end else if (rdy) begin
            if (commit_fire)
                perf_commit_cnt <= perf_commit_cnt + XLEN'(1);
            if (mispredict)
                perf_flush_cnt <= perf_flush_cnt + XLEN'(1);
        end
    end
`else
    // Performance counters are not built in this configuration.
`endif
endmodule

// File: tb/tb_reorder_buffer_param.sv
// tb_reorder_buffer_param: directed and randomized bench for
// reorder_buffer_param. A queue-based reference model tracks in-flight
// entries by ID and predicts lookups, flags and the registered pulses.
module tb_reorder_buffer_param;
    localparam int DEPTH = 16;
    localparam int ID_W  = 5;
    localparam int XLEN  = 32;
    localparam int AFULL = DEPTH - 3;

    logic clk = 1'b0;
    logic rst;
    logic rdy;

    reorder_buffer_param_if #(.DEPTH(DEPTH), .ID_W(ID_W), .XLEN(XLEN)) bus ();

`ifdef ROB_PERF_CNT_EN
    logic [XLEN-1:0] perf_commit_cnt;
    logic [XLEN-1:0] perf_flush_cnt;
`endif

    reorder_buffer_param #(.DEPTH(DEPTH), .ID_W(ID_W), .XLEN(XLEN), .AFULL_MARGIN(3)) dut (
        .clk(clk),
        .rst(rst),
        .rdy(rdy),
        .bus(bus)
`ifdef ROB_PERF_CNT_EN
        ,
        .perf_commit_cnt(perf_commit_cnt),
        .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [4:0]  rd;
        logic [31:0] pc, rb, tgt, val;
        bit          jmp, st, pt, tk, rdy_e, io;
    } ent_t;

    ent_t mq[$];
    int   m_next;
    int   m_pcnt, m_fcnt;
    logic        e_cv, e_fl, e_bpv, e_bpt;
    logic [4:0]  e_crd;
    logic [31:0] e_cid, e_cval, e_fpc, e_bppc;

    int  n_checks = 0;
    int  n_errs   = 0;
    bit  collect  = 0;
    int  cid_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [32:0] m_lookup(input int tag);
        if (tag == 0) return '0;
        if (bus.lsu_valid && int'(bus.lsu_id) == tag) return {1'b1, bus.lsu_value};
        if (bus.alu_valid && int'(bus.alu_id) == tag) return {1'b1, bus.alu_value};
        foreach (mq[i])
            if (mq[i].id == tag) return mq[i].rdy_e ? {1'b1, mq[i].val} : 33'd0;
        return '0;
    endfunction

    task automatic model_step();
        int n;
        bit c, mis;
        if (rst) begin
            mq.delete();
            m_next = 1; m_pcnt = 0; m_fcnt = 0;
            e_cv = 0; e_fl = 0; e_bpv = 0; e_bpt = 0;
            e_cid = 0; e_crd = 0; e_cval = 0; e_fpc = 0; e_bppc = 0;
            return;
        end
        if (!rdy) return;
        n   = mq.size();
        c   = (n > 0) && (mq[0].rdy_e || mq[0].st);
        mis = 0;
        e_cv = c; e_fl = 0; e_bpv = 0;
        if (c) begin
            m_pcnt++;
            e_cid = mq[0].id; e_crd = mq[0].rd; e_cval = mq[0].val;
            if (mq[0].jmp) begin
                e_bpv = 1; e_bppc = mq[0].pc; e_bpt = mq[0].tk;
                if (mq[0].tk != mq[0].pt) begin
                    mis = 1; e_fl = 1;
                    e_fpc = mq[0].tk ? mq[0].tgt : mq[0].rb;
                end
            end
        end
        if (mis) begin
            m_fcnt++;
            mq.delete();
            m_next = 1;
            return;
        end
        foreach (mq[i]) begin
            if (bus.alu_valid && int'(bus.alu_id) == mq[i].id) begin
                mq[i].rdy_e = 1; mq[i].val = bus.alu_value;
                mq[i].tgt = bus.alu_target_pc; mq[i].tk = bus.alu_taken;
            end
            if (bus.lsu_valid && int'(bus.lsu_id) == mq[i].id) begin
                mq[i].rdy_e = 1; mq[i].val = bus.lsu_value;
            end
            if (int'(bus.io_mark_id) == mq[i].id) mq[i].io = 1;
        end
        if (c) void'(mq.pop_front());
        if (bus.alloc_valid && n < DEPTH) begin
            ent_t e;
            e.id = m_next; e.rd = bus.alloc_rd; e.pc = bus.alloc_pc;
            e.rb = bus.alloc_rollback_pc; e.tgt = 0; e.val = 0;
            e.jmp = bus.alloc_is_jump; e.st = bus.alloc_is_store;
            e.pt = bus.alloc_pred_taken; e.tk = 0; e.rdy_e = 0; e.io = 0;
            mq.push_back(e);
            m_next = m_next % DEPTH + 1;
        end
    endtask

    task automatic check_comb();
        logic [32:0] l1, l2;
        if (rst) return;
        l1 = m_lookup(int'(bus.q1_id));
        l2 = m_lookup(int'(bus.q2_id));
        chk("alloc_id", bus.alloc_id, m_next);
        chk("full", bus.full, mq.size() == DEPTH);
        chk("empty", bus.empty, mq.size() == 0);
        chk("almost_full", bus.almost_full, mq.size() >= AFULL);
        chk("io_head_id", bus.io_head_id, (mq.size() > 0 && mq[0].io) ? mq[0].id : 0);
        chk("q1", {bus.q1_ready, bus.v1}, l1);
        chk("q2", {bus.q2_ready, bus.v2}, l2);
    endtask

    task automatic check_regs();
        chk("commit_valid", bus.commit_valid, e_cv);
        if (e_cv) begin
            chk("commit_id", bus.commit_id, e_cid);
            chk("commit_rd", bus.commit_rd, e_crd);
            chk("commit_value", bus.commit_value, e_cval);
        end
        chk("flush", bus.flush, e_fl);
        if (e_fl) chk("flush_pc", bus.flush_pc, e_fpc);
        chk("bp_valid", bus.bp_valid, e_bpv);
        if (e_bpv) begin
            chk("bp_pc", bus.bp_pc, e_bppc);
            chk("bp_taken", bus.bp_taken, e_bpt);
        end
`ifdef ROB_PERF_CNT_EN
        chk("perf_commit_cnt", perf_commit_cnt, m_pcnt);
        chk("perf_flush_cnt", perf_flush_cnt, m_fcnt);
`endif
    endtask

    task automatic cycle();
        #2;
        check_comb();
        model_step();
        @(posedge clk);
        #1;
        check_regs();
        if (collect && bus.commit_valid) cid_q.push_back(int'(bus.commit_id));
    endtask

    task automatic idle();
        bus.alloc_valid = 0; bus.alloc_is_jump = 0; bus.alloc_is_store = 0;
        bus.alloc_pred_taken = 0; bus.alloc_rd = 0; bus.alloc_pc = 0;
        bus.alloc_rollback_pc = 0; bus.q1_id = 0; bus.q2_id = 0;
        bus.alu_valid = 0; bus.alu_id = 0; bus.alu_value = 0;
        bus.alu_target_pc = 0; bus.alu_taken = 0;
        bus.lsu_valid = 0; bus.lsu_id = 0; bus.lsu_value = 0;
        bus.io_mark_id = 0;
    endtask

    task automatic alloc(input bit j, input bit s, input bit pt, input logic [31:0] pc);
        bus.alloc_valid = 1; bus.alloc_is_jump = j; bus.alloc_is_store = s;
        bus.alloc_pred_taken = pt; bus.alloc_rd = 5'($urandom);
        bus.alloc_pc = pc; bus.alloc_rollback_pc = pc + 4;
    endtask

    task automatic do_reset();
        rst = 1; rdy = 1; idle();
        cycle();
        cycle();
        rst = 0;
    endtask

    initial begin
        rst = 1; rdy = 1; idle();
        @(posedge clk); #1;
        do_reset();

        // Reset state
        chk("rst_commit_valid", bus.commit_valid, 0);
        chk("rst_commit_id", bus.commit_id, 0);
        chk("rst_commit_value", bus.commit_value, 0);
        chk("rst_flush", bus.flush, 0);
        chk("rst_flush_pc", bus.flush_pc, 0);
        chk("rst_bp_valid", bus.bp_valid, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_alloc_id", bus.alloc_id, 1);

        // Fill to full, then one ignored allocation
        for (int i = 0; i < DEPTH; i++) begin
            alloc(0, 0, 0, $urandom);
            #1;
            chk("fill_alloc_id", bus.alloc_id, i + 1);
            chk("fill_afull", bus.almost_full, i >= AFULL);
            cycle();
        end
        chk("fill_full", bus.full, 1);
        alloc(0, 0, 0, $urandom);
        cycle();
        chk("ovf_full", bus.full, 1);
        chk("ovf_alloc_id", bus.alloc_id, 1);

        // Broadcast every ID, then drain
        collect = 1;
        for (int i = 1; i <= DEPTH; i++) begin
            idle();
            bus.alu_valid = 1; bus.alu_id = ID_W'(i); bus.alu_value = $urandom;
            bus.q1_id = ID_W'(i);
            cycle();
        end
        idle();
        for (int k = 0; k < 20 && !bus.empty; k++) cycle();
        collect = 0;
        chk("drain_empty", bus.empty, 1);
        chk("drain_n", cid_q.size(), DEPTH);
        foreach (cid_q[i]) chk("drain_id", cid_q[i], i + 1);
        cid_q.delete();

        // Wrap-around with four or five entries in flight
        do_reset();
        collect = 1;
        for (int k = 0; k < 28; k++) begin
            idle();
            if (k < 20) alloc(0, 0, 0, $urandom);
            if (k >= 3 && k - 3 < 20) begin
                bus.lsu_valid = 1; bus.lsu_id = ID_W'((k - 3) % DEPTH + 1);
                bus.lsu_value = $urandom;
            end
            cycle();
        end
        collect = 0;
        chk("wrap_n", cid_q.size(), 20);
        foreach (cid_q[i]) chk("wrap_id", cid_q[i], i % DEPTH + 1);
        cid_q.delete();

        // Bypass and ALU/LSU conflict
        do_reset();
        for (int i = 0; i < 4; i++) begin
            idle(); alloc(0, 0, 0, $urandom); cycle();
        end
        idle();
        bus.alu_valid = 1; bus.alu_id = 3; bus.alu_value = 32'hDEADBEEF;
        bus.q1_id = 3; bus.q2_id = 0;
        #1;
        chk("byp_q1_ready", bus.q1_ready, 1);
        chk("byp_v1", bus.v1, 32'hDEADBEEF);
        chk("byp_q2_ready", bus.q2_ready, 0);
        chk("byp_v2", bus.v2, 0);
        cycle();
        idle();
        bus.alu_valid = 1; bus.alu_id = 2; bus.alu_value = 32'h1111_2222;
        bus.lsu_valid = 1; bus.lsu_id = 2; bus.lsu_value = 32'h3333_4444;
        cycle();
        idle();
        bus.q1_id = 2; bus.q2_id = 3;
        #1;
        chk("conf_q1_ready", bus.q1_ready, 1);
        chk("conf_v1", bus.v1, 32'h3333_4444);
        chk("stored_v2", bus.v2, 32'hDEADBEEF);
        cycle();

        // Mispredicted jump flushes the buffer
        do_reset();
        idle(); alloc(1, 0, 0, 32'h200); cycle();
        for (int i = 0; i < 3; i++) begin
            idle(); alloc(0, 0, 0, $urandom); cycle();
        end
        idle();
        bus.alu_valid = 1; bus.alu_id = 1; bus.alu_taken = 1;
        bus.alu_target_pc = 32'h1000; bus.alu_value = $urandom;
        cycle();
        idle();
        alloc(0, 0, 0, $urandom);
        bus.lsu_valid = 1; bus.lsu_id = 2; bus.lsu_value = $urandom;
        cycle();
        chk("mp_flush", bus.flush, 1);
        chk("mp_flush_pc", bus.flush_pc, 32'h1000);
        chk("mp_bp_valid", bus.bp_valid, 1);
        chk("mp_bp_taken", bus.bp_taken, 1);
        chk("mp_bp_pc", bus.bp_pc, 32'h200);
        chk("mp_commit_id", bus.commit_id, 1);
        idle();
        #1;
        chk("mp_empty", bus.empty, 1);
        chk("mp_alloc_id", bus.alloc_id, 1);
`ifdef ROB_PERF_CNT_EN
        chk("mp_perf_flush", perf_flush_cnt, 1);
        chk("mp_perf_commit", perf_commit_cnt, 1);
`endif
        cycle();
        chk("mp_flush_end", bus.flush, 0);

        // Store commits without a broadcast; stall holds everything
        do_reset();
        idle(); alloc(0, 1, 0, 32'h300); cycle();
        idle(); alloc(0, 0, 0, 32'h304); cycle();
        chk("st_commit_valid", bus.commit_valid, 1);
        chk("st_commit_id", bus.commit_id, 1);
        rdy = 0;
        for (int i = 0; i < 3; i++) begin
            idle();
            alloc(0, 0, 0, $urandom);
            bus.lsu_valid = 1; bus.lsu_id = 2; bus.lsu_value = $urandom;
            bus.io_mark_id = 2;
            cycle();
            chk("stall_commit_valid", bus.commit_valid, 1);
            chk("stall_commit_id", bus.commit_id, 1);
            chk("stall_alloc_id", bus.alloc_id, 3);
            chk("stall_empty", bus.empty, 0);
        end
        rdy = 1;
        idle(); bus.io_mark_id = 2; cycle();
        idle();
        #1;
        chk("io_head_id", bus.io_head_id, 2);
        bus.lsu_valid = 1; bus.lsu_id = 2; bus.lsu_value = 32'hCAFE_F00D;
        cycle();
        idle(); cycle();
        chk("st2_commit_id", bus.commit_id, 2);
        chk("st2_commit_value", bus.commit_value, 32'hCAFE_F00D);

        // Randomized traffic against the model
        do_reset();
        for (int k = 0; k < 400; k++) begin
            idle();
            rdy = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 9) < 6) begin
                if ($urandom_range(0, 3) == 0) alloc(1, 0, 1'($urandom), $urandom);
                else alloc(0, 1'($urandom_range(0, 5) == 0), 0, $urandom);
            end
            if (mq.size() > 0 && $urandom_range(0, 2) != 0) begin
                int pick;
                pick = mq[$urandom_range(0, mq.size() - 1)].id;
                if ($urandom_range(0, 1) == 0) begin
                    bus.alu_valid = 1; bus.alu_id = ID_W'(pick);
                    bus.alu_value = $urandom; bus.alu_target_pc = $urandom;
                    bus.alu_taken = 1'($urandom);
                end
                if ($urandom_range(0, 2) == 0) begin
                    bus.lsu_valid = 1; bus.lsu_id = ID_W'(pick);
                    bus.lsu_value = $urandom;
                end
            end
            if ($urandom_range(0, 4) == 0) bus.io_mark_id = ID_W'($urandom_range(0, DEPTH));
            bus.q1_id = ID_W'($urandom_range(0, DEPTH));
            bus.q2_id = ID_W'($urandom_range(0, DEPTH));
            cycle();
        end
        rdy = 1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule
